// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b - b_in, LSB first, one full-subtractor cell
//               plus a borrow flop, with valid/ready operand and result ports.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int            C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              br_q, br_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic              w_d;
  logic              w_br;
  logic [WIDTH-1:0]  w_res_next;

  // Single full-subtractor cell; the difference bit enters the result MSB.
  assign w_d        = a_q[0] ^ b_q[0] ^ br_q;
  assign w_br       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign w_res_next = (res_q >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = b_in;
          res_d   = '0;
          cnt_d   = '0;
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = w_res_next;
        br_d  = w_br;
        if (cnt_q == C_LAST) begin
          // Results are captured here so the outputs never show a partial sum.
          diff_d  = w_res_next;
          bout_d  = w_br;
          ovf_d   = (sa_q != sb_q) && (w_res_next[WIDTH-1] != sa_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign diff  = diff_q;
  assign b_out = bout_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire
